// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared WIDTH-bit 2:1 output mux: drives sel and the
// valid/ready handshake, bounding each ownership to MAX_BURST transfers under contention.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | no owner; sel = 0, out_valid = 0
//  OWN_A | requester A owns the channel; sel = 0
//  OWN_B | requester B owns the channel; sel = 1
module mux_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             sel,
    output logic             busy,
    output logic [3:0]       burst_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;   // last owner: 0 = A, 1 = B
    logic [3:0] cnt_q, cnt_d;

    logic       own_a, own_b;
    logic       own_req, oth_req;
    logic       oth_id;
    state_t     oth_state;
    logic       xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        own_a     = (state_q == OWN_A);
        own_b     = (state_q == OWN_B);
        out_valid = (own_a & req_a) | (own_b & req_b);
        xfer      = out_valid & out_ready;
        ack_a     = own_a & xfer;
        ack_b     = own_b & xfer;
        sel       = own_b;
        busy      = (state_q != IDLE);
        burst_cnt = cnt_q;
        out_data  = sel ? data_b : data_a;
    end

    // The OWN states are handled symmetrically via "own" and "other" views.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        own_req   = own_b ? req_b : req_a;
        oth_req   = own_b ? req_a : req_b;
        oth_state = own_b ? OWN_A : OWN_B;
        oth_id    = ~own_b;

        case (state_q)
            IDLE: begin
                if (req_a && (!req_b || last_q)) begin
                    state_d = OWN_A;
                    last_d  = 1'b0;
                    cnt_d   = 4'd0;
                end else if (req_b) begin
                    state_d = OWN_B;
                    last_d  = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            OWN_A, OWN_B: begin
                if (!own_req) begin
                    cnt_d = 4'd0;
                    if (oth_req) begin
                        state_d = oth_state;
                        last_d  = oth_id;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        // Burst window exhausted: hand off if contended, else restart window.
                        cnt_d = 4'd0;
                        if (oth_req) begin
                            state_d = oth_state;
                            last_d  = oth_id;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: stimulus pushes expected transfers into a
// scoreboard queue; a negedge monitor pops and compares on every handshake.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b, out_ready;
    logic [3:0] data_a, data_b;
    logic       ack_a, ack_b, out_valid, sel, busy;
    logic [3:0] out_data, burst_cnt;

    typedef struct packed {
        logic       sel;
        logic [3:0] data;
        logic [3:0] cnt;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    mux_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel),
        .busy      (busy),
        .burst_cnt (burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic s, input logic [3:0] d, input logic [3:0] c);
        exp_t e;
        e.sel  = s;
        e.data = d;
        e.cnt  = c;
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        out_ready = 1'b0;
        data_a    = 4'h9;
        data_b    = 4'h6;
        #7;
        tick();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_xfer: got transfer sel=%0b data=%0h cnt=%0d, expected none (t=%0t)",
                         sel, out_data, burst_cnt, $time);
            end else begin
                mon_e = expq.pop_front();
                chk("xfer_sel",   {7'd0, sel},   {7'd0, mon_e.sel});
                chk("xfer_ack_a", {7'd0, ack_a}, {7'd0, ~mon_e.sel});
                chk("xfer_ack_b", {7'd0, ack_b}, {7'd0, mon_e.sel});
                chk("xfer_data",  {4'd0, out_data},  {4'd0, mon_e.data});
                chk("xfer_cnt",   {4'd0, burst_cnt}, {4'd0, mon_e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
        data_a = 4'h9; data_b = 4'h6;
        #3;
        chk("rst_sel",   {7'd0, sel},       8'd0);
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_busy",  {7'd0, busy},      8'd0);
        chk("rst_cnt",   {4'd0, burst_cnt}, 8'd0);
        chk("rst_data",  {4'd0, out_data},  8'h09);

        // Single requester
        do_reset();
        req_a = 1'b1; data_a = 4'h5; out_ready = 1'b1;
        push(1'b0, 4'h5, 4'd0);
        push(1'b0, 4'h5, 4'd1);
        push(1'b0, 4'h5, 4'd2);
        samp();
        chk("single_c0_valid", {7'd0, out_valid}, 8'd0);
        chk("single_c0_busy",  {7'd0, busy},      8'd0);
        for (int k = 1; k <= 3; k++) begin
            tick(); samp();
            chk("single_valid", {7'd0, out_valid}, 8'd1);
            chk("single_ack_a", {7'd0, ack_a},     8'd1);
            chk("single_sel",   {7'd0, sel},       8'd0);
        end
        tick(); req_a = 1'b0;
        samp();
        chk("single_rel_valid", {7'd0, out_valid}, 8'd0);
        chk("single_rel_busy",  {7'd0, busy},      8'd1);
        tick(); samp();
        chk("single_idle_busy", {7'd0, busy}, 8'd0);

        // Contention, MAX_BURST = 4
        do_reset();
        req_a = 1'b1; req_b = 1'b1; data_a = 4'hA; data_b = 4'hB; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b0, 4'hA, 4'(i));
        for (int i = 0; i < 4; i++) push(1'b1, 4'hB, 4'(i));
        push(1'b0, 4'hA, 4'd0);
        samp();
        chk("cont_c0_valid", {7'd0, out_valid}, 8'd0);
        for (int c = 1; c <= 9; c++) begin
            tick(); samp();
            chk("cont_valid", {7'd0, out_valid}, 8'd1);
            chk("cont_sel",   {7'd0, sel}, (c >= 5 && c <= 8) ? 8'd1 : 8'd0);
        end
        tick(); req_a = 1'b0; req_b = 1'b0;
        tick();

        // Back-pressure
        do_reset();
        req_a = 1'b1; data_a = 4'h3; out_ready = 1'b1;
        push(1'b0, 4'h3, 4'd0);
        tick(); samp();
        tick(); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("bp_valid", {7'd0, out_valid}, 8'd1);
            chk("bp_ack_a", {7'd0, ack_a},     8'd0);
            chk("bp_cnt",   {4'd0, burst_cnt}, 8'd1);
            chk("bp_data",  {4'd0, out_data},  8'h03);
            tick();
        end
        out_ready = 1'b1;
        push(1'b0, 4'h3, 4'd1);
        samp();
        chk("bp_resume_ack", {7'd0, ack_a}, 8'd1);
        tick(); req_a = 1'b0; out_ready = 1'b0;
        tick();

        // Burst exhaustion without contention
        do_reset();
        req_a = 1'b1; data_a = 4'h1; out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) push(1'b0, 4'(k), 4'((k - 1) % 4));
        tick();
        for (int k = 1; k <= 8; k++) begin
            samp();
            chk("exh_sel", {7'd0, sel}, 8'd0);
            tick();
            data_a = 4'(k + 1);
        end
        req_a = 1'b0;
        tick();

        // Early release with B waiting
        do_reset();
        req_a = 1'b1; req_b = 1'b1; data_a = 4'h7; data_b = 4'h9; out_ready = 1'b1;
        push(1'b0, 4'h7, 4'd0);
        tick(); samp();
        tick(); req_a = 1'b0;
        samp();
        chk("rel_gap_valid", {7'd0, out_valid}, 8'd0);
        chk("rel_gap_ack_b", {7'd0, ack_b},     8'd0);
        tick();
        push(1'b1, 4'h9, 4'd0);
        samp();
        chk("rel_b_sel", {7'd0, sel},       8'd1);
        chk("rel_b_cnt", {4'd0, burst_cnt}, 8'd0);
        tick(); req_b = 1'b0;
        tick();

        // Round-robin priority follows the last owner
        do_reset();
        req_a = 1'b1; data_a = 4'h1; out_ready = 1'b1;
        push(1'b0, 4'h1, 4'd0);
        tick(); samp();
        tick(); req_a = 1'b0;
        samp();
        tick(); req_a = 1'b1; req_b = 1'b1; data_b = 4'h6;
        samp();
        chk("rr_idle_busy", {7'd0, busy}, 8'd0);
        tick();
        push(1'b1, 4'h6, 4'd0);
        samp();
        chk("rr_b_first", {7'd0, sel}, 8'd1);
        tick(); req_b = 1'b0;
        samp();
        chk("rr_b_rel_valid", {7'd0, out_valid}, 8'd0);
        tick();
        push(1'b0, 4'h1, 4'd0);
        samp();
        chk("rr_a_back", {7'd0, sel}, 8'd0);
        tick(); req_a = 1'b0;
        tick();

        // Reset mid-burst in OWN_B
        do_reset();
        req_b = 1'b1; data_b = 4'hC; data_a = 4'h2; out_ready = 1'b1;
        push(1'b1, 4'hC, 4'd0);
        push(1'b1, 4'hC, 4'd1);
        tick(); samp();
        tick(); samp();
        tick(); out_ready = 1'b0;
        #1;
        chk("mid_pre_cnt", {4'd0, burst_cnt}, 8'd2);
        chk("mid_pre_sel", {7'd0, sel},       8'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel",   {7'd0, sel},       8'd0);
        chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_ack_b", {7'd0, ack_b},     8'd0);
        chk("mid_rst_busy",  {7'd0, busy},      8'd0);
        chk("mid_rst_cnt",   {4'd0, burst_cnt}, 8'd0);
        chk("mid_rst_data",  {4'd0, out_data},  8'h02);
        tick();
        rst_n = 1'b1; req_a = 1'b1; out_ready = 1'b1;
        push(1'b0, 4'h2, 4'd0);
        tick(); samp();
        chk("mid_after_a_first", {7'd0, sel}, 8'd0);
        tick(); req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
        tick(); tick();

        chk("queue_empty", 8'(expq.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
